mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting a single-port RAM to an icache and a dcache.
// Handles abort on request drop, RAM ERROR status and a saturating watchdog.
module mem_arbiter #(
   parameter int unsigned WDOG_MAX = 255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] IACC = 2'd1;
   localparam logic [1:0] DACC = 2'd2;

   localparam logic [1:0] RamAccess = 2'd2;
   localparam logic [1:0] RamError  = 2'd3;

   logic [1:0] state_q, state_d;
   logic       last_d_q, last_d_d;  // 1: dcache was granted last
   logic [7:0] wdog_q, wdog_d;
   logic       err_q, err_d;

   logic i_req, d_req, act, hit, fault, tmo, done;

   assign i_req = iREN;
   assign d_req = dREN | dWEN;
   assign hit   = (ramstate == RamAccess);
   assign fault = (ramstate == RamError);
   // Timeout fires on the cycle whose wait would bring the count to WDOG_MAX.
   assign tmo   = ((32'(wdog_q) + 32'd1) >= WDOG_MAX);
   assign err   = err_q;

   always_comb begin
      act = 1'b0;
      if (state_q == IACC) act = i_req;
      else if (state_q == DACC) act = d_req;
   end

   assign done = act & (hit | fault | tmo);

   always_comb begin
      state_d  = state_q;
      last_d_d = last_d_q;
      wdog_d   = wdog_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            wdog_d = '0;
            if (i_req && d_req) state_d = last_d_q ? IACC : DACC;
            else if (i_req)     state_d = IACC;
            else if (d_req)     state_d = DACC;
         end
         IACC, DACC: begin
            if (!act) begin
               state_d = IDLE;
            end else if (done) begin
               state_d  = IDLE;
               last_d_d = (state_q == DACC);
               if (!hit) err_d = 1'b1;
            end else if (wdog_q != 8'hFF) begin
               wdog_d = wdog_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (act) begin
         case (state_q)
            IACC: begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (done) begin
                  iwait = 1'b0;
                  iload = hit ? ramload : '0;
               end
            end
            DACC: begin
               ramaddr  = daddr;
               ramstore = dstore;
               ramWEN   = dWEN;
               ramREN   = dREN & ~dWEN;
               if (done) begin
                  dwait = 1'b0;
                  dload = (hit && !dWEN) ? ramload : '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= IDLE;
         last_d_q <= 1'b0;
         wdog_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_d_q <= last_d_d;
         wdog_q   <= wdog_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// all outputs compared each cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int unsigned WDOG = 255;
   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;
   logic        iwait, dwait, ramREN, ramWEN, err;
   logic [31:0] iload, dload, ramaddr, ramstore;

   always #5 CLK = ~CLK;

   mem_arbiter #(.WDOG_MAX(WDOG)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   int nchk = 0;
   int npass = 0;
   int nfail = 0;

   // Reference model: who owns the RAM, how long it has waited, fairness, sticky error.
   int m_owner;  // 0 none, 1 icache, 2 dcache
   bit m_last_d;
   int m_wait;
   bit m_err;

   task automatic model_reset();
      m_owner = 0; m_last_d = 1'b0; m_wait = 0; m_err = 1'b0;
   endtask

   function automatic logic [132:0] obs_vec();
      return {iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err};
   endfunction

   function automatic logic [132:0] exp_vec();
      logic iw = 1'b1, dw = 1'b1, rr = 1'b0, rw = 1'b0;
      logic [31:0] il = '0, dl = '0, ra = '0, rs = '0;
      bit fin;
      fin = (ramstate == ACCESS) || (ramstate == ERROR) || (m_wait + 1 >= WDOG);
      if (m_owner == 1 && iREN) begin
         rr = 1'b1; ra = iaddr;
         if (fin) begin iw = 1'b0; il = (ramstate == ACCESS) ? ramload : 32'd0; end
      end else if (m_owner == 2 && (dREN || dWEN)) begin
         ra = daddr; rs = dstore; rw = dWEN; rr = dREN && !dWEN;
         if (fin) begin dw = 1'b0; dl = (ramstate == ACCESS && !dWEN) ? ramload : 32'd0; end
      end
      return {iw, il, dw, dl, rr, rw, ra, rs, m_err};
   endfunction

   task automatic chk(input string tag, input logic [132:0] obs, input logic [132:0] exp);
      nchk++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] ds, input logic [31:0] rl, input logic [1:0] st);
      iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
      ramload = rl; ramstate = st;
      #2;
      chk(tag, obs_vec(), exp_vec());
   endtask

   task automatic tick();
      bit ir, dq, fin;
      @(posedge CLK);
      if (!nRST) begin
         model_reset();
      end else begin
         ir = iREN; dq = dREN || dWEN;
         fin = (ramstate == ACCESS) || (ramstate == ERROR) || (m_wait + 1 >= WDOG);
         if (m_owner == 0) begin
            m_wait = 0;
            if (ir && dq) m_owner = m_last_d ? 1 : 2;
            else if (ir)  m_owner = 1;
            else if (dq)  m_owner = 2;
         end else if ((m_owner == 1 && !ir) || (m_owner == 2 && !dq)) begin
            m_owner = 0;
         end else if (fin) begin
            m_last_d = (m_owner == 2);
            if (ramstate != ACCESS) m_err = 1'b1;
            m_owner = 0;
         end else if (m_wait < 255) begin
            m_wait++;
         end
      end
      #1;
   endtask

   initial begin
      nRST = 1'b0;
      iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
      ramload = 0; ramstate = FREE;
      model_reset();
      #3;
      chk("reset_outputs", obs_vec(), {1'b1, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0, 64'd0, 1'b0});
      @(posedge CLK);
      @(posedge CLK);
      #1;
      nRST = 1'b1;

      // Single icache fetch completing on the 3rd granted cycle.
      step("r29_idle", 1, 32'h40, 0, 0, 0, 0, 32'h8C220004, BUSY);
      chk("r29_idle_noram", 133'(ramREN), 133'd0);
      tick();
      for (int k = 1; k <= 3; k++) begin
         step("r29_acc", 1, 32'h40, 0, 0, 0, 0, 32'h8C220004, (k == 3) ? ACCESS : BUSY);
         chk("r29_ramren", 133'(ramREN), 133'd1);
         chk("r29_ramaddr", 133'(ramaddr), 133'h40);
         chk("r29_iwait", 133'(iwait), (k == 3) ? 133'd0 : 133'd1);
         if (k == 3) chk("r29_iload", 133'(iload), 133'h8C220004);
         tick();
      end
      step("r29_after", 0, 0, 0, 0, 0, 0, 0, FREE);
      chk("r29_after_iwait", 133'(iwait), 133'd1);
      tick();

      // Simultaneous requests alternate D, I, D, I.
      for (int g = 0; g < 4; g++) begin
         step("r30_idle", 1, 32'h80, 1, 0, 32'h200, 0, 32'h1234, ACCESS);
         tick();
         step("r30_acc", 1, 32'h80, 1, 0, 32'h200, 0, 32'h1234, ACCESS);
         chk("r30_dwait", 133'(dwait), (g % 2 == 0) ? 133'd0 : 133'd1);
         chk("r30_iwait", 133'(iwait), (g % 2 == 0) ? 133'd1 : 133'd0);
         tick();
      end
      step("r30_after", 0, 0, 0, 0, 0, 0, 0, FREE);
      tick();

      // Write takes priority over read when both asserted.
      step("r31_idle", 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h55, BUSY);
      tick();
      step("r31_busy", 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h55, BUSY);
      chk("r31_ramwen", 133'({ramWEN, ramREN}), 133'b10);
      chk("r31_ramstore", 133'(ramstore), 133'hDEADBEEF);
      chk("r31_dwait_busy", 133'(dwait), 133'd1);
      tick();
      step("r31_acc", 0, 0, 1, 1, 32'h100, 32'hDEADBEEF, 32'h55, ACCESS);
      chk("r31_dwait", 133'({dwait, dload}), 133'd0);
      tick();
      step("r31_after", 0, 0, 0, 0, 0, 0, 0, FREE);
      tick();

      // icache abort while BUSY, pending dcache read then granted.
      step("r32_idle", 1, 32'h44, 1, 0, 32'h300, 0, 32'h77, BUSY);
      tick();
      step("r32_iacc", 1, 32'h44, 1, 0, 32'h300, 0, 32'h77, BUSY);
      chk("r32_iacc_addr", 133'({ramREN, ramaddr}), {100'd0, 1'b1, 32'h44});
      tick();
      step("r32_drop", 0, 32'h44, 1, 0, 32'h300, 0, 32'h77, BUSY);
      chk("r32_drop_ram", 133'({ramREN, iwait}), 133'b01);
      tick();
      step("r32_idle2", 0, 0, 1, 0, 32'h300, 0, 32'h77, BUSY);
      tick();
      step("r32_dacc", 0, 0, 1, 0, 32'h300, 0, 32'h77, ACCESS);
      chk("r32_dacc", 133'({ramREN, ramaddr, dwait, dload}), {67'd0, 1'b1, 32'h300, 1'b0, 32'h77});
      tick();
      step("r32_after", 0, 0, 0, 0, 0, 0, 0, FREE);
      tick();

      // Watchdog abort after 255 BUSY cycles.
      step("r33_idle", 0, 0, 1, 0, 32'h500, 0, 32'h99, BUSY);
      tick();
      for (int c = 1; c <= 255; c++) begin
         step("r33_busy", 0, 0, 1, 0, 32'h500, 0, 32'h99, BUSY);
         chk("r33_dwait", 133'(dwait), (c == 255) ? 133'd0 : 133'd1);
         if (c == 255) chk("r33_dload", 133'(dload), 133'd0);
         tick();
      end
      for (int c = 0; c < 4; c++) begin
         step("r33_after", 0, 0, 0, 0, 0, 0, 0, FREE);
         chk("r33_err", 133'(err), 133'd1);
         tick();
      end

      // Asynchronous reset in the middle of a dcache write.
      step("r34_idle", 0, 0, 1, 1, 32'h600, 32'h11, 0, BUSY);
      tick();
      step("r34_busy", 0, 0, 1, 1, 32'h600, 32'h11, 0, BUSY);
      chk("r34_pre", 133'(ramWEN), 133'd1);
      nRST = 1'b0;
      #1;
      chk("r34_async", 133'({ramWEN, ramREN, err, dwait}), 133'b0001);
      model_reset();
      tick();
      nRST = 1'b1;
      step("r34_rel_idle", 1, 32'h70, 1, 0, 32'h700, 0, 32'h5, BUSY);
      tick();
      step("r34_regrant", 1, 32'h70, 1, 0, 32'h700, 0, 32'h5, ACCESS);
      chk("r34_regrant_d", 133'({ramaddr, dwait}), {100'd0, 32'h700, 1'b0});
      tick();

      // Random traffic, including aborts and ERROR responses.
      for (int n = 0; n < 1500; n++) begin
         int r;
         logic [1:0] st;
         r = int'($urandom_range(0, 99));
         st = (r < 15) ? FREE : (r < 40) ? BUSY : (r < 95) ? ACCESS : ERROR;
         step("rand", ($urandom_range(0, 99) < 70), $urandom,
              ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 30),
              $urandom, $urandom, $urandom, st);
         tick();
      end

      $display("%0d/%0d checks passed", npass, nchk);
      $finish;
   end

endmodule
